edge_pe_nbr_stream_rx: RTL and testbench
========================================

// Module: edge_pe_nbr_stream_rx
// PURPOSE
// - Per-Edge-PE receiver for one lane of the Neighbor BUS output (sos/eos/Neighbor_num_Iter/Neighbor_id).
// - Buffers streamed neighbor IDs in a small FIFO and replays them to the FV fetch path with a valid/ready handshake.
// - Closes each stream with a one-cycle done pulse that carries the neighbor count.
// - One instance per Edge PE (Num_Edge_PE = 4).
// PARAMETERS
// - NBR_ID_W    14  neighbor ID width (= Neighbor_ID_bandwidth)
// - ITER_W      3   Neighbor_num_Iter width (= $clog2(max_degree_Iter))
// - FIFO_DEPTH  8   ID buffer entries; power of 2, >= 2
// - CNT_W       10  neighbor counter width; saturates at 2^CNT_W-1
// PORTS
// - clk            in   1         clock
// - reset          in   1         asynchronous, active-low reset (0 = reset)
// - nbr_sos        in   1         start of stream; the beat also carries an ID
// - nbr_eos        in   1         end of stream; the beat also carries an ID (may coincide with sos)
// - nbr_iter       in   ITER_W    Neighbor_num_Iter; sampled on the sos beat
// - nbr_id         in   NBR_ID_W  neighbor ID of the current beat
// - fv_req_valid   out  1         FIFO head valid toward the FV fetch
// - fv_req_ready   in   1         FV fetch accepts the head
// - fv_req_id      out  NBR_ID_W  head neighbor ID
// - fv_req_iter    out  ITER_W    iteration tag of the current stream
// - fv_req_last    out  1         head is the last ID of the stream
// - busy           out  1         stream in progress or FIFO not yet drained
// - nbr_done       out  1         one-cycle pulse after the last ID is handed off
// - nbr_count      out  CNT_W     IDs accepted this stream; valid while nbr_done=1
// - ovf_err        out  1         sticky: dropped beat (FIFO full or protocol violation)
// BEHAVIOUR
// - Reset:
//   - All outputs 0. FIFO pointers 0. FSM = IDLE. ovf_err cleared only by reset.
//   - Reset mid-stream discards all buffered IDs; no nbr_done is issued.
// - Beat acceptance:
//   - A beat exists when (state==IDLE && nbr_sos) or state==STREAM.
//   - The input has no backpressure: a valid beat is written the same cycle if the FIFO is not full.
//   - Otherwise the beat is dropped and ovf_err is set. A dropped eos still ends the stream.
// - FSM:
//   - IDLE -> STREAM on sos without eos.
//   - IDLE -> DRAIN on sos with eos (single neighbor).
//   - STREAM -> DRAIN on eos.
//   - DRAIN -> DONE when the last-tagged entry pops (valid&ready), or when the FIFO is empty.
//   - DONE -> IDLE after 1 cycle. nbr_done=1 only in DONE.
// - Tagging and count:
//   - On sos: nbr_iter is latched into fv_req_iter, and the counter is loaded with 1 (or 0 if the beat is dropped).
//   - Each accepted eos beat is written with last=1.
//   - The counter increments per accepted beat and saturates at 2^CNT_W-1.
// - Protocol violations:
//   - sos while in STREAM/DRAIN/DONE: beat dropped, ovf_err set, state unchanged.
//   - eos in IDLE without sos: ignored, ovf_err set.
// - FIFO:
//   - First-word fall-through. Latency from beat to fv_req_valid is 1 cycle.
//   - A write and a pop in the same cycle are both honoured when full: the pop frees the slot first, so no drop.
//   - Pointers are ITER-independent and wrap modulo FIFO_DEPTH.
//   - Head outputs are stable while valid&&!ready.
// - busy:
//   - busy = (state!=IDLE).
//   - The scheduler must not issue a new PE_tag request for this PE while busy=1.
// CONFIGURATION
// - NBR_RX_DEDUP_EN defined:
//   - An accepted beat whose ID equals the previous accepted ID of the same stream is not written to the FIFO and is not counted.
//   - If that beat has eos, last=1 is retro-applied to the FIFO tail entry.
//   - If the FIFO is empty, the FSM goes straight to DONE.
// - NBR_RX_DEDUP_EN undefined: every beat is buffered and counted; no comparator logic.
// TESTING
// - Single beat: sos=eos=1, id=0x2A, iter=3, ready=1.
//   -> next cycle valid=1, id=0x2A, last=1, iter=3; nbr_done 1 cycle later with count=1.
// - 5-beat stream (ids 10..14), ready held 0 for 6 cycles then 1.
//   -> FIFO holds 5; IDs pop in order; last only on 14; done with count=5.
// - 10-beat stream, FIFO_DEPTH=8, ready=0.
//   -> beats 9,10 dropped; ovf_err=1; stream still closes; count=8.
// - Full FIFO with simultaneous pop and write.
//   -> no drop; ovf_err stays 0.
// - reset=0 asserted mid-stream after 3 beats.
//   -> outputs 0 immediately; no nbr_done; next sos stream behaves normally.
// - NBR_RX_DEDUP_EN: ids 7,7,9,9(eos).
//   -> popped 7,9 (last on 9); count=2.

Source files
------------

// File: rtl/edge_pe_nbr_stream_rx_if.sv
// Neighbor-BUS lane input plus FV fetch request/handshake bundle for one Edge PE receiver.
interface edge_pe_nbr_stream_rx_if #(
  parameter int NBR_ID_W = 14,
  parameter int ITER_W   = 3,
  parameter int CNT_W    = 10
);
  logic                nbr_sos;
  logic                nbr_eos;
  logic [ITER_W-1:0]   nbr_iter;
  logic [NBR_ID_W-1:0] nbr_id;
  logic                fv_req_valid;
  logic                fv_req_ready;
  logic [NBR_ID_W-1:0] fv_req_id;
  logic [ITER_W-1:0]   fv_req_iter;
  logic                fv_req_last;
  logic                busy;
  logic                nbr_done;
  logic [CNT_W-1:0]    nbr_count;
  logic                ovf_err;

  modport master (
    output nbr_sos, nbr_eos, nbr_iter, nbr_id, fv_req_ready,
    input  fv_req_valid, fv_req_id, fv_req_iter, fv_req_last,
    input  busy, nbr_done, nbr_count, ovf_err
  );

  modport slave (
    input  nbr_sos, nbr_eos, nbr_iter, nbr_id, fv_req_ready,
    output fv_req_valid, fv_req_id, fv_req_iter, fv_req_last,
    output busy, nbr_done, nbr_count, ovf_err
  );
endinterface

// File: rtl/edge_pe_nbr_stream_rx.sv
// Per-Edge-PE Neighbor-BUS receiver: FWFT ID FIFO toward FV fetch, done pulse with count.
// Optional build macro NBR_RX_DEDUP_EN drops back-to-back repeated IDs within a stream.
module edge_pe_nbr_stream_rx #(
  parameter int NBR_ID_W   = 14,
  parameter int ITER_W     = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  edge_pe_nbr_stream_rx_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        fill_q, fill_d;
  logic [FIFO_DEPTH-1:0] last_q, last_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [NBR_ID_W-1:0]   id_mem [FIFO_DEPTH];

  logic head_vld, pop, room, sos_idle, beat, viol, dup, wr_en, drop;

`ifdef NBR_RX_DEDUP_EN
  logic [NBR_ID_W-1:0] prev_id_q, prev_id_d;
  logic                prev_vld_q, prev_vld_d;
`endif

  always_comb begin
    head_vld = (fill_q != '0);
    pop      = head_vld && bus.fv_req_ready;
    // a pop in the same cycle frees the slot, so a full FIFO can still take the beat
    room     = (fill_q != FULL_LVL) || pop;
    sos_idle = (state_q == IDLE) && bus.nbr_sos;
    beat     = sos_idle || ((state_q == STREAM) && !bus.nbr_sos);
    viol     = (bus.nbr_sos && (state_q != IDLE)) ||
               ((state_q == IDLE) && bus.nbr_eos && !bus.nbr_sos);
    dup      = 1'b0;
`ifdef NBR_RX_DEDUP_EN
    dup      = (state_q == STREAM) && beat && prev_vld_q && (bus.nbr_id == prev_id_q);
`endif
    wr_en    = beat && !dup && room;
    drop     = beat && !dup && !room;
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    iter_d   = iter_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
`ifdef NBR_RX_DEDUP_EN
    prev_id_d  = prev_id_q;
    prev_vld_d = prev_vld_q;
`endif

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (wr_en) begin
      last_d[wr_ptr_q] = bus.nbr_eos;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    fill_d = fill_q + (PTR_W+1)'(wr_en) - (PTR_W+1)'(pop);

    if (drop || viol) begin
      ovf_d = 1'b1;
    end

    if (sos_idle) begin
      iter_d = bus.nbr_iter;
      cnt_d  = wr_en ? CNT_W'(1) : '0;
    end else if (wr_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE:    if (bus.nbr_sos) state_d = bus.nbr_eos ? DRAIN : STREAM;
      STREAM:  if (beat && bus.nbr_eos) state_d = DRAIN;
      DRAIN:   if ((pop && last_q[rd_ptr_q]) || !head_vld) state_d = DONE;
      default: state_d = IDLE;
    endcase

`ifdef NBR_RX_DEDUP_EN
    if (wr_en) begin
      prev_id_d  = bus.nbr_id;
      prev_vld_d = 1'b1;
    end else if (state_q == DONE) begin
      prev_vld_d = 1'b0;
    end
    // a duplicate eos moves the last tag onto the entry already buffered
    if (dup && bus.nbr_eos) begin
      if (head_vld) begin
        last_d[wr_ptr_q - PTR_W'(1)] = 1'b1;
      end else begin
        state_d = DONE;
      end
    end
`endif

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      last_q   <= '0;
      iter_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef NBR_RX_DEDUP_EN
      prev_id_q  <= '0;
      prev_vld_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      last_q   <= last_d;
      iter_q   <= iter_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef NBR_RX_DEDUP_EN
      prev_id_q  <= prev_id_d;
      prev_vld_q <= prev_vld_d;
`endif
    end
  end

  // ID storage carries no reset; the head outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (wr_en) begin
      id_mem[wr_ptr_q] <= bus.nbr_id;
    end
  end

  assign bus.fv_req_valid = head_vld;
  assign bus.fv_req_id    = head_vld ? id_mem[rd_ptr_q] : '0;
  assign bus.fv_req_last  = head_vld && last_q[rd_ptr_q];
  assign bus.fv_req_iter  = iter_q;
  assign bus.busy         = busy_q;
  assign bus.nbr_done     = done_q;
  assign bus.nbr_count    = cnt_q;
  assign bus.ovf_err      = ovf_q;
endmodule

// File: tb/tb_edge_pe_nbr_stream_rx.sv
// Bench for edge_pe_nbr_stream_rx: vector table, hand-written corner sequences and
// random streams checked against a queue-based reference of the receiver behaviour.
module tb_edge_pe_nbr_stream_rx;
  localparam int NBR_ID_W   = 14;
  localparam int ITER_W     = 3;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  edge_pe_nbr_stream_rx_if #(.NBR_ID_W(NBR_ID_W), .ITER_W(ITER_W), .CNT_W(CNT_W)) bus ();

  edge_pe_nbr_stream_rx #(
    .NBR_ID_W(NBR_ID_W), .ITER_W(ITER_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic        sos;
    logic        eos;
    logic [2:0]  iter;
    logic [13:0] id;
    logic        rdy;
    logic        e_valid;
    logic [13:0] e_id;
    logic        e_last;
    logic        e_busy;
    logic        e_done;
    logic [9:0]  e_cnt;
    logic [2:0]  e_iter;
  } vec_t;

  vec_t        vecs [15];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [14:0] mq [$];
  logic [13:0] sid [16];
  bit          ovf_exp = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic drive(input logic sos, input logic eos, input logic [2:0] iter,
                       input logic [13:0] id, input logic rdy);
    bus.nbr_sos      = sos;
    bus.nbr_eos      = eos;
    bus.nbr_iter     = iter;
    bus.nbr_id       = id;
    bus.fv_req_ready = rdy;
  endtask

  // Streams sid[0..n-1] back to back; ready is 0 for 'hold' cycles, then 1 with prob% chance.
  task automatic run_stream(input int n, input logic [2:0] iter, input int hold,
                            input int prob, input string tag);
    int          beat = 0;
    int          acc  = 0;
    int          cyc  = 0;
    bit          done_seen = 1'b0;
    bit          prev_v    = 1'b0;
    bit          dup;
    logic        rdy;
    logic [13:0] prev = '0;
    logic [14:0] ent;
    mq.delete();
    while (!done_seen && cyc < 300) begin
      chk({tag, " valid"}, bus.fv_req_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        ent = mq[0];
        chk({tag, " id"},   bus.fv_req_id,   ent[13:0]);
        chk({tag, " last"}, bus.fv_req_last, ent[14]);
        chk({tag, " iter"}, bus.fv_req_iter, iter);
      end
      if (bus.nbr_done) begin
        done_seen = 1'b1;
        chk({tag, " done_early"}, (beat == n) && (mq.size() == 0), 1);
        chk({tag, " count"}, bus.nbr_count, (acc > 1023) ? 1023 : acc);
        chk({tag, " ovf"}, bus.ovf_err, ovf_exp);
        drive(1'b0, 1'b0, 3'd0, 14'd0, 1'b0);
        tick();
        chk({tag, " done_pulse"}, bus.nbr_done, 0);
        chk({tag, " busy_after"}, bus.busy, 0);
      end else begin
        chk({tag, " busy"}, bus.busy, beat > 0);
        rdy = (cyc < hold) ? 1'b0 : ($urandom_range(99) < prob);
        if (beat < n)
          drive(beat == 0, beat == n - 1, (beat == 0) ? iter : 3'($urandom), sid[beat], rdy);
        else
          drive(1'b0, 1'b0, 3'($urandom), 14'($urandom), rdy);
        if ((mq.size() != 0) && rdy) void'(mq.pop_front());
        if (beat < n) begin
          dup = 1'b0;
`ifdef NBR_RX_DEDUP_EN
          dup = prev_v && (sid[beat] == prev);
`endif
          if (dup) begin
            if ((beat == n - 1) && (mq.size() != 0)) begin
              ent = mq[mq.size() - 1];
              ent[14] = 1'b1;
              mq[mq.size() - 1] = ent;
            end
          end else if (mq.size() < FIFO_DEPTH) begin
            mq.push_back({beat == n - 1, sid[beat]});
            acc++;
            prev   = sid[beat];
            prev_v = 1'b1;
          end else begin
            ovf_exp = 1'b1;
          end
          beat++;
        end
        cyc++;
        tick();
      end
    end
    if (!done_seen) chk({tag, " timeout"}, 0, 1);
    $display("%s: beats=%0d accepted=%0d count=%0d ovf=%0d", tag, n, acc, bus.nbr_count, bus.ovf_err);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    bit   got_done;
    int   n;
    int   pr;
    int   hold;

    //            sos eos it id     rdy | val id     last busy done cnt it
    vecs[0]  = '{1, 1, 3, 14'h2A, 1,  1, 14'h2A, 1, 1, 0, 1, 3};
    vecs[1]  = '{0, 0, 0, 0,      1,  0, 0,      0, 1, 1, 1, 3};
    vecs[2]  = '{0, 0, 0, 0,      1,  0, 0,      0, 0, 0, 1, 3};
    vecs[3]  = '{1, 0, 5, 10,     0,  1, 10,     0, 1, 0, 1, 5};
    vecs[4]  = '{0, 0, 0, 11,     0,  1, 10,     0, 1, 0, 2, 5};
    vecs[5]  = '{0, 0, 0, 12,     0,  1, 10,     0, 1, 0, 3, 5};
    vecs[6]  = '{0, 0, 0, 13,     0,  1, 10,     0, 1, 0, 4, 5};
    vecs[7]  = '{0, 1, 0, 14,     0,  1, 10,     0, 1, 0, 5, 5};
    vecs[8]  = '{0, 0, 0, 0,      0,  1, 10,     0, 1, 0, 5, 5};
    vecs[9]  = '{0, 0, 0, 0,      1,  1, 11,     0, 1, 0, 5, 5};
    vecs[10] = '{0, 0, 0, 0,      1,  1, 12,     0, 1, 0, 5, 5};
    vecs[11] = '{0, 0, 0, 0,      1,  1, 13,     0, 1, 0, 5, 5};
    vecs[12] = '{0, 0, 0, 0,      1,  1, 14,     1, 1, 0, 5, 5};
    vecs[13] = '{0, 0, 0, 0,      1,  0, 0,      0, 1, 1, 5, 5};
    vecs[14] = '{0, 0, 0, 0,      1,  0, 0,      0, 0, 0, 5, 5};

    drive(1'b0, 1'b0, 3'd0, 14'd0, 1'b0);
    tick();
    tick();
    chk("reset valid", bus.fv_req_valid, 0);
    chk("reset busy",  bus.busy, 0);
    chk("reset done",  bus.nbr_done, 0);
    chk("reset ovf",   bus.ovf_err, 0);
    chk("reset count", bus.nbr_count, 0);
    chk("reset iter",  bus.fv_req_iter, 0);
    @(negedge clk) reset = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].sos, vecs[i].eos, vecs[i].iter, vecs[i].id, vecs[i].rdy);
      tick();
      chk($sformatf("vec%0d valid", i), bus.fv_req_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d id", i),    bus.fv_req_id,    vecs[i].e_id);
      chk($sformatf("vec%0d last", i),  bus.fv_req_last,  vecs[i].e_last);
      chk($sformatf("vec%0d busy", i),  bus.busy,         vecs[i].e_busy);
      chk($sformatf("vec%0d done", i),  bus.nbr_done,     vecs[i].e_done);
      chk($sformatf("vec%0d count", i), bus.nbr_count,    vecs[i].e_cnt);
      chk($sformatf("vec%0d iter", i),  bus.fv_req_iter,  vecs[i].e_iter);
    end
    chk("vec ovf clear", bus.ovf_err, 0);

    // 10 beats into an 8-deep FIFO with ready low: beats 9 and 10 are lost
    for (int i = 0; i < 10; i++) begin
      drive(i == 0, i == 9, 3'd2, 14'(100 + i), 1'b0);
      tick();
    end
    chk("ovf set",   bus.ovf_err, 1);
    chk("ovf count", bus.nbr_count, 8);
    chk("ovf busy",  bus.busy, 1);
    chk("ovf head",  bus.fv_req_id, 100);
    k = 0;
    got_done = 1'b0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      drive(1'b0, 1'b0, 3'd0, 14'd0, 1'b1);
      if (bus.nbr_done) begin
        got_done = 1'b1;
      end else begin
        if (bus.fv_req_valid) begin
          chk($sformatf("ovf pop%0d id", k), bus.fv_req_id, 100 + k);
          chk($sformatf("ovf pop%0d last", k), bus.fv_req_last, 0);
          k++;
        end
        tick();
      end
    end
    chk("ovf pops",       k, 8);
    chk("ovf done seen",  got_done, 1);
    chk("ovf done count", bus.nbr_count, 8);
    $display("overflow stream: beats=10 popped=%0d count=%0d", k, bus.nbr_count);
    drive(1'b0, 1'b0, 3'd0, 14'd0, 1'b0);
    tick();

    // asynchronous reset in the middle of a stream
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, 1'b0, 3'd6, 14'(300 + i), 1'b0);
      tick();
    end
    chk("mid busy", bus.busy, 1);
    drive(1'b0, 1'b0, 3'd0, 14'd0, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst valid", bus.fv_req_valid, 0);
    chk("rst id",    bus.fv_req_id, 0);
    chk("rst busy",  bus.busy, 0);
    chk("rst ovf",   bus.ovf_err, 0);
    chk("rst count", bus.nbr_count, 0);
    chk("rst iter",  bus.fv_req_iter, 0);
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rst no_done%0d", i), bus.nbr_done, 0);
      chk($sformatf("rst idle%0d", i), bus.busy, 0);
    end
    $display("mid-stream reset: outputs cleared");

    // eos without sos in IDLE is a protocol violation
    drive(1'b0, 1'b1, 3'd0, 14'd5, 1'b0);
    tick();
    chk("viol ovf",  bus.ovf_err, 1);
    chk("viol busy", bus.busy, 0);
    drive(1'b0, 1'b0, 3'd0, 14'd0, 1'b0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    ovf_exp = 1'b0;
    tick();

    // fill to 8, then pop and write together: nothing may be lost
    for (int i = 0; i < 12; i++) sid[i] = 14'(200 + i);
    run_stream(12, 3'd4, 8, 100, "full pop+write");
    chk("fpw no ovf", bus.ovf_err, 0);

`ifdef NBR_RX_DEDUP_EN
    sid[0] = 14'd7;
    sid[1] = 14'd7;
    sid[2] = 14'd9;
    sid[3] = 14'd9;
    run_stream(4, 3'd1, 4, 100, "dedup");
`endif

    for (int s = 0; s < 40; s++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) sid[i] = 14'($urandom_range(0, 20));
      case ($urandom_range(0, 2))
        0:       pr = 30;
        1:       pr = 70;
        default: pr = 100;
      endcase
      hold = $urandom_range(0, 10);
      run_stream(n, 3'($urandom), hold, pr, $sformatf("random%0d", s));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
